stream_uart_tx: RTL
===================

Name: stream_uart_tx

Overview:
- Consumer end of the 32-bit stb/ack stream that the design drives out on output_rs232_tx.
- Accepts words from the stream into a small FIFO.
- Serialises the low byte of each word as 8N1 asynchronous serial on the board TX pin.
- Sits outside user_design in the board top, between the rs232_tx stream and the FPGA pin.

Parameters:
- CLOCK_FREQUENCY, 100000000, clk frequency in Hz.
- BAUD_RATE, 115200, line rate in bit/s. DIVISOR = CLOCK_FREQUENCY/BAUD_RATE, integer division, must be >= 2.
- FIFO_DEPTH, 16, word buffer depth; power of 2, >= 2.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst  input  1  reset, asynchronous assert, active-low (0 = reset).
- in  input  32  stream data; only bits [7:0] are transmitted, [31:8] are ignored.
- in_stb  input  1  producer holds high with stable data until in_ack is seen.
- in_ack  output  1  one-cycle accept pulse.
- tx  output  1  serial line, idle high.
- busy  output  1  high while a frame is on the line or the FIFO is non-empty.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  number of buffered words.

Behaviour:
- Reset (rst=0, takes effect immediately):
  - tx=1, in_ack=0, busy=0, fifo_count=0, state IDLE, baud counter 0, FIFO emptied.
  - Any frame in progress is abandoned and tx returns high.
- Input handshake:
  - in_ack is registered.
  - At a rising edge where in_stb=1, in_ack=0 and the FIFO is not full, in[7:0] is written to the FIFO and in_ack goes 1 for exactly one cycle.
  - in_ack is never high in two consecutive cycles, so the maximum accept rate is one word per 2 cycles.
  - FIFO full: in_ack stays 0 and the producer stalls. No overflow and no data loss.
  - A word written while the FIFO has exactly one free slot makes it full. The next accept waits for a pop.
- FIFO:
  - Synchronous, first-word-fall-through read.
  - Simultaneous push and pop in one cycle is legal, including when full: the pop frees the slot and the push lands. fifo_count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Transmit FSM, one state per frame field:
  - IDLE: tx=1. If the FIFO is non-empty: pop into shift register, load baud counter with DIVISOR-1, go to START.
  - START: tx=0 for DIVISOR cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0] (LSB first) for DIVISOR cycles per bit. Shift right after each bit. After bit 7 go to STOP.
  - STOP: tx=1 for DIVISOR cycles. At the end, if the FIFO is non-empty, pop and go straight to START (no extra idle bit); else go to IDLE.
  - Baud counter counts down and the field ends when it reaches 0. Frame length is exactly 10*DIVISOR cycles.
  - tx is registered.
- Latency: with FSM IDLE and FIFO empty, tx falls on the 2nd rising edge after the edge that sets in_ack.
- busy = (state != IDLE) or (fifo_count != 0). It is registered-consistent with state and has no glitches.

Decomposition:
- Shared package uart_pkg:
  - FSM state enum (IDLE, START, DATA, STOP).
  - DATA_BITS=8.
  - Function computing DIVISOR and the counter width from the parameters.
- One natural sub-module: stream_fifo, a parameterised synchronous FIFO with push/pop/full/empty/count.
- The FSM and handshake stay in stream_uart_tx.

Test Plan (CLOCK_FREQUENCY=16, BAUD_RATE=1, DIVISOR=16, FIFO_DEPTH=4 unless noted):
- Reset state: hold rst=0 for 5 cycles with in_stb=1 → tx=1, in_ack=0, busy=0, fifo_count=0. Release → first in_ack one cycle later.
- Single byte: in=0x12345655, one handshake → tx low 16 cycles, then bits 1,0,1,0,1,0,1,0 at 16 cycles each, then high 16 cycles. Total 160 cycles. busy falls after the stop bit. Upper bits are ignored.
- Back-to-back: send 0x00 then 0xFF → the second start bit begins on the cycle after the first stop bit ends, with no idle gap. The two frames span 320 cycles.
- Backpressure: hold in_stb=1 continuously with 6 distinct words → 5 accepts (1 popped into the shifter plus 4 buffered), then in_ack stays 0 until the first frame's stop pop. All 6 bytes appear on tx in order and none are duplicated.
- Handshake spacing: in_stb held high → in_ack pattern is 1,0,1,0 with no consecutive highs. Count matches FIFO writes.
- Reset mid-frame: assert rst during DATA bit 3 → tx=1 asynchronously. After release the FIFO is empty, busy=0, and no partial frame resumes.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the stream-to-UART transmitter.
//   - uart_state_e     : transmit FSM state, one state per 8N1 frame field
//   - DATA_BITS        : payload bits per frame
//   - calc_divisor     : clock cycles per serial bit
//   - calc_count_width : width of a down-counter that must hold divisor-1
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    function automatic int calc_divisor(input int clock_frequency, input int baud_rate);
        return clock_frequency / baud_rate;
    endfunction

    // The baud counter is loaded with divisor-1, so $clog2(divisor) bits are
    // enough; never return less than one bit.
    function automatic int calc_count_width(input int divisor);
        return (divisor <= 2) ? 1 : $clog2(divisor);
    endfunction

endpackage

// File: rtl/stream_fifo.sv
// Synchronous first-word-fall-through FIFO.
//   clk, rst        : clock, asynchronous active-low reset
//   push, push_data : write request and data
//   pop             : consume the word currently on pop_data
//   pop_data        : head of the FIFO, valid whenever empty=0
//   full, empty     : occupancy flags
//   count           : number of stored words (0..DEPTH)
// A push while full is accepted when it coincides with a pop; the pop frees
// the slot that the push then fills.
module stream_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count_reg == '0);
    assign full     = (count_reg == (AW+1)'(DEPTH));
    assign count    = count_reg;
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    // Fall-through head: the oldest word is visible without a read request.
    assign pop_data = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/stream_uart_tx.sv
// Stream consumer that buffers words and sends their low byte as 8N1 serial.
//   clk        : system clock
//   rst        : asynchronous active-low reset
//   in         : stream data, only in[7:0] is transmitted
//   in_stb     : producer strobe, held with stable data until in_ack
//   in_ack     : registered one-cycle accept pulse
//   tx         : serial line, idle high
//   busy       : a frame is on the line or words are still buffered
//   fifo_count : number of buffered words
module stream_uart_tx
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQUENCY = 100000000,
    parameter int BAUD_RATE       = 115200,
    parameter int FIFO_DEPTH      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [31:0]                   in,
    input  logic                          in_stb,
    output logic                          in_ack,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int DIVISOR = calc_divisor(CLOCK_FREQUENCY, BAUD_RATE);
    localparam int CNT_W   = calc_count_width(DIVISOR);
    localparam int FCNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] BAUD_LOAD = CNT_W'(DIVISOR - 1);
    localparam logic [2:0]       LAST_BIT  = 3'(DATA_BITS - 1);

    uart_state_e          state_reg, state_next;
    logic [CNT_W-1:0]     baud_cnt_reg, baud_cnt_next;
    logic [2:0]           bit_idx_reg, bit_idx_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic                 tx_reg;
    logic                 ack_reg;
    logic                 busy_reg;

    logic                 fifo_push;
    logic                 fifo_pop;
    logic [DATA_BITS-1:0] fifo_head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [FCNT_W-1:0]    fifo_count_next;
    logic                 line_level;
    logic [23:0]          unused_upper;

    assign unused_upper = in[31:8];

    // Accepting only when in_ack is low spaces accepts at least two cycles apart.
    assign fifo_push = in_stb && !ack_reg && !fifo_full;

    stream_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (in[7:0]),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        state_next    = state_reg;
        baud_cnt_next = baud_cnt_reg;
        bit_idx_next  = bit_idx_reg;
        shift_next    = shift_reg;
        fifo_pop      = 1'b0;

        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop      = 1'b1;
                    shift_next    = fifo_head;
                    baud_cnt_next = BAUD_LOAD;
                    state_next    = START;
                end
            end
            START: begin
                if (baud_cnt_reg == '0) begin
                    baud_cnt_next = BAUD_LOAD;
                    bit_idx_next  = '0;
                    state_next    = DATA;
                end else begin
                    baud_cnt_next = baud_cnt_reg - 1'b1;
                end
            end
            DATA: begin
                if (baud_cnt_reg == '0) begin
                    baud_cnt_next = BAUD_LOAD;
                    shift_next    = shift_reg >> 1;
                    if (bit_idx_reg == LAST_BIT) begin
                        state_next = STOP;
                    end else begin
                        bit_idx_next = bit_idx_reg + 1'b1;
                    end
                end else begin
                    baud_cnt_next = baud_cnt_reg - 1'b1;
                end
            end
            STOP: begin
                if (baud_cnt_reg == '0) begin
                    // Chain straight into the next start bit when data is waiting.
                    if (!fifo_empty) begin
                        fifo_pop      = 1'b1;
                        shift_next    = fifo_head;
                        baud_cnt_next = BAUD_LOAD;
                        state_next    = START;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    baud_cnt_next = baud_cnt_reg - 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Line level implied by the current field; registered into tx one cycle later.
    always_comb begin
        case (state_reg)
            START:   line_level = 1'b0;
            DATA:    line_level = shift_reg[0];
            default: line_level = 1'b1;
        endcase
    end

    // Occupancy after this edge; busy is built from next-state values so the
    // output is a flop and cannot glitch.
    assign fifo_count_next = fifo_count + FCNT_W'(fifo_push) - FCNT_W'(fifo_pop && !fifo_empty);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            baud_cnt_reg <= '0;
            bit_idx_reg  <= '0;
            shift_reg    <= '0;
            tx_reg       <= 1'b1;
            ack_reg      <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            baud_cnt_reg <= baud_cnt_next;
            bit_idx_reg  <= bit_idx_next;
            shift_reg    <= shift_next;
            tx_reg       <= line_level;
            ack_reg      <= fifo_push;
            busy_reg     <= (state_next != IDLE) || (fifo_count_next != '0);
        end
    end

    assign tx     = tx_reg;
    assign in_ack = ack_reg;
    assign busy   = busy_reg;

endmodule
